apb_rd_resp_fifo: RTL and testbench

- Downstream consumer of the APB system's read-response stream (rd_valid/rd_data).
- Buffers every returned 32-bit read word in a first-word-fall-through FIFO and presents it to a downstream sink with a valid/ready handshake.
- The APB side has no back-pressure, so words arriving while the FIFO is full are dropped and counted.
- Sits between the APB top and any host/logging logic that drains read data at its own pace.

---
 rtl/apb_rd_resp_fifo.sv | 149 ++++++++++++++
 tb/tb_apb_rd_resp_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rd_resp_fifo.sv
// rtl/apb_rd_resp_fifo.sv - first-word-fall-through buffer for the APB read-response stream
//
// Purpose:
//   Captures every read word returned by the APB top (rd_valid_i/rd_data_i)
//   into a DEPTH-entry FWFT FIFO and presents the head entry to a downstream
//   sink through a valid/ready handshake. The APB side cannot be stalled, so
//   a word that arrives while the FIFO is full (and nothing is popped in that
//   cycle) is discarded. Discarded words set a sticky overflow flag and bump
//   a saturating drop counter.
//
// Optional feature (macro RD_RESP_SUM_EN):
//   Adds sum_o, a running modulo-2^DW sum of every accepted word. Dropped
//   words are excluded. The sum is cleared by reset and by clr_i.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   rd_valid_i   in   one-cycle pulse, read word present
//   rd_data_i    in   read word, sampled only when rd_valid_i=1
//   out_valid_o  out  head entry available
//   out_data_o   out  head entry, 0 when out_valid_o=0
//   out_ready_i  in   sink accepts the head entry this cycle
//   level_o      out  occupancy, 0..DEPTH
//   full_o       out  level_o == DEPTH
//   empty_o      out  level_o == 0
//   overflow_o   out  sticky, at least one word dropped since reset/clear
//   drop_cnt_o   out  saturating count of dropped words
//   clr_i        in   synchronous clear of overflow_o and drop_cnt_o
//   sum_o        out  running sum of accepted words (RD_RESP_SUM_EN only)

module apb_rd_resp_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_valid_i,
  input  logic [DW-1:0]            rd_data_i,
  output logic                     out_valid_o,
  output logic [DW-1:0]            out_data_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  output logic [CW-1:0]            drop_cnt_o,
`ifdef RD_RESP_SUM_EN
  output logic [DW-1:0]            sum_o,
`endif
  input  logic                     clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d;

  logic pop;
  logic push;
  logic drop;

  always_comb begin
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    pop  = (level_q != '0) && out_ready_i;
    push = rd_valid_i && ((level_q != FULL_LVL) || pop);
    drop = rd_valid_i && (level_q == FULL_LVL) && !pop;

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;

    // Pointer width equals log2(DEPTH), so the increment wraps by itself.
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;

    // A drop coinciding with a clear is counted as the first drop after it.
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_i)                      drop_cnt_d = CW'(1);
      else if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (clr_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; the level counter alone decides validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rd_data_i;
  end

`ifdef RD_RESP_SUM_EN
  logic [DW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    // Mirrors the drop counter: a word accepted alongside a clear starts the
    // new sum rather than being lost.
    if (clr_i) sum_d = push ? rd_data_i : '0;
    else if (push) sum_d = sum_q + rd_data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign sum_o = sum_q;
`endif

  assign out_valid_o = (level_q != '0);
  assign out_data_o  = out_valid_o ? mem[rd_ptr_q] : '0;
  assign level_o     = level_q;
  assign full_o      = (level_q == FULL_LVL);
  assign empty_o     = (level_q == '0);
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_apb_rd_resp_fifo.sv
// tb/tb_apb_rd_resp_fifo.sv - directed self-checking bench for apb_rd_resp_fifo

module tb_apb_rd_resp_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int CW    = 16;

  logic          clk;
  logic          reset;
  logic          rd_valid_i;
  logic [DW-1:0] rd_data_i;
  logic          out_valid_o;
  logic [DW-1:0] out_data_o;
  logic          out_ready_i;
  logic [3:0]    level_o;
  logic          full_o;
  logic          empty_o;
  logic          overflow_o;
  logic [CW-1:0] drop_cnt_o;
  logic          clr_i;
`ifdef RD_RESP_SUM_EN
  logic [DW-1:0] sum_o;
`endif

  int n_cmp;
  int n_err;

  apb_rd_resp_fifo #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_valid_i  (rd_valid_i),
    .rd_data_i   (rd_data_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .level_o     (level_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .overflow_o  (overflow_o),
    .drop_cnt_o  (drop_cnt_o),
`ifdef RD_RESP_SUM_EN
    .sum_o       (sum_o),
`endif
    .clr_i       (clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rd_valid_i  = 1'b0;
    rd_data_i   = '0;
    out_ready_i = 1'b0;
    clr_i       = 1'b0;
    do_reset();
    n_cmp++; if (level_o !== 4'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid_o); end
    n_cmp++; if (out_data_o !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", out_data_o); end
    n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
    n_cmp++; if (drop_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_drop got %0d want 0", drop_cnt_o); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_words [3];
    exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33;
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_valid_i = 1'b1;
      rd_data_i  = exp_words[i];
      step();
    end
    rd_valid_i = 1'b0;
    n_cmp++; if (level_o !== 4'd3) begin n_err++; $display("FAIL basic_level got %0d want 3", level_o); end
    n_cmp++; if (out_data_o !== 32'h11) begin n_err++; $display("FAIL basic_head got %h want 11", out_data_o); end
    n_cmp++; if (empty_o !== 1'b0) begin n_err++; $display("FAIL basic_empty got %b want 0", empty_o); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_data_o !== exp_words[i]) begin n_err++; $display("FAIL basic_pop%0d got %h want %h", i, out_data_o, exp_words[i]); end
      step();
    end
    out_ready_i = 1'b0;
    n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL basic_drained_empty got %b want 1", empty_o); end
    n_cmp++; if (out_data_o !== 32'h0) begin n_err++; $display("FAIL basic_drained_data got %h want 0", out_data_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_drained_valid got %b want 0", out_valid_o); end
  endtask

  task automatic test_overflow();
    out_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_valid_i = 1'b1;
      rd_data_i  = 32'hA0 + i;
      step();
    end
    rd_valid_i = 1'b0;
    n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b want 1", full_o); end
    n_cmp++; if (level_o !== 4'd8) begin n_err++; $display("FAIL ovf_level got %0d want 8", level_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow_o); end
    n_cmp++; if (drop_cnt_o !== 16'd2) begin n_err++; $display("FAIL ovf_drop got %0d want 2", drop_cnt_o); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (out_data_o !== 32'hA0 + i) begin n_err++; $display("FAIL ovf_drain%0d got %h want %h", i, out_data_o, 32'hA0 + i); end
      step();
    end
    out_ready_i = 1'b0;
    n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL ovf_drained_empty got %b want 1", empty_o); end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] exp_order [8];
    for (int i = 0; i < 8; i++) begin
      rd_valid_i = 1'b1;
      rd_data_i  = 32'hB0 + i;
      step();
    end
    rd_valid_i  = 1'b1;
    rd_data_i   = 32'hC0;
    out_ready_i = 1'b1;
    step();
    rd_valid_i = 1'b0;
    out_ready_i = 1'b0;
    n_cmp++; if (level_o !== 4'd8) begin n_err++; $display("FAIL fpp_level got %0d want 8", level_o); end
    n_cmp++; if (drop_cnt_o !== 16'd0) begin n_err++; $display("FAIL fpp_drop got %0d want 0", drop_cnt_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL fpp_ovf got %b want 0", overflow_o); end
    for (int i = 0; i < 7; i++) exp_order[i] = 32'hB1 + i;
    exp_order[7] = 32'hC0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (out_data_o !== exp_order[i]) begin n_err++; $display("FAIL fpp_drain%0d got %h want %h", i, out_data_o, exp_order[i]); end
      step();
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_latency();
    out_ready_i = 1'b1;
    step();
    n_cmp++; if (level_o !== 4'd0) begin n_err++; $display("FAIL lat_empty_ready got %0d want 0", level_o); end
    rd_valid_i = 1'b1;
    rd_data_i  = 32'h5;
    step();
    rd_valid_i = 1'b0;
    n_cmp++; if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL lat_valid got %b want 1", out_valid_o); end
    n_cmp++; if (out_data_o !== 32'h5) begin n_err++; $display("FAIL lat_data got %h want 5", out_data_o); end
    n_cmp++; if (level_o !== 4'd1) begin n_err++; $display("FAIL lat_level1 got %0d want 1", level_o); end
    step();
    n_cmp++; if (level_o !== 4'd0) begin n_err++; $display("FAIL lat_level0 got %0d want 0", level_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL lat_popped got %b want 0", out_valid_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_clear();
    out_ready_i = 1'b0;
    for (int i = 0; i < 11; i++) begin
      rd_valid_i = 1'b1;
      rd_data_i  = 32'hD0 + i;
      step();
    end
    rd_valid_i = 1'b0;
    n_cmp++; if (drop_cnt_o !== 16'd3) begin n_err++; $display("FAIL clr_pre_drop got %0d want 3", drop_cnt_o); end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %b want 0", overflow_o); end
    n_cmp++; if (drop_cnt_o !== 16'd0) begin n_err++; $display("FAIL clr_drop got %0d want 0", drop_cnt_o); end
    clr_i      = 1'b1;
    rd_valid_i = 1'b1;
    rd_data_i  = 32'hEE;
    step();
    clr_i      = 1'b0;
    rd_valid_i = 1'b0;
    n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL clr_drop_wins_ovf got %b want 1", overflow_o); end
    n_cmp++; if (drop_cnt_o !== 16'd1) begin n_err++; $display("FAIL clr_drop_wins_cnt got %0d want 1", drop_cnt_o); end
    n_cmp++; if (level_o !== 4'd8) begin n_err++; $display("FAIL clr_level got %0d want 8", level_o); end
    n_cmp++; if (out_data_o !== 32'hD0) begin n_err++; $display("FAIL clr_head got %h want d0", out_data_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rd_valid_i = 1'b1;
      rd_data_i  = 32'hF0 + i;
      step();
    end
    rd_valid_i = 1'b0;
    n_cmp++; if (level_o !== 4'd5) begin n_err++; $display("FAIL arst_pre_level got %0d want 5", level_o); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (level_o !== 4'd0) begin n_err++; $display("FAIL arst_level got %0d want 0", level_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b want 0", out_valid_o); end
    n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL arst_empty got %b want 1", empty_o); end
    step();
    reset = 1'b0;
    step();
    n_cmp++; if (out_data_o !== 32'h0) begin n_err++; $display("FAIL arst_after_data got %h want 0", out_data_o); end
  endtask

`ifdef RD_RESP_SUM_EN
  task automatic test_sum();
    do_reset();
    rd_valid_i = 1'b1;
    rd_data_i  = 32'hFFFF_FFFF;
    step();
    rd_data_i  = 32'h2;
    step();
    rd_valid_i = 1'b0;
    n_cmp++; if (sum_o !== 32'h1) begin n_err++; $display("FAIL sum_wrap got %h want 1", sum_o); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_latency();
    test_clear();
    test_async_reset();
`ifdef RD_RESP_SUM_EN
    test_sum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
